// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART line-buffer receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       err;
    } uart_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_wr;
    logic             do_rd;

    // A write while full is accepted only when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rptr[AW-1:0]];
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;

endmodule

// File: rtl/uart_rx_line_buffer.sv
// rtl/uart_rx_line_buffer.sv - UART receiver with frame checks, byte FIFO and line tracking
module uart_rx_line_buffer
    import uart_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          BIT_RATE     = 9600,
    parameter int          PAYLOAD_BITS = 8,
    parameter int          PARITY       = 0,
    parameter int          STOP_BITS    = 1,
    parameter int          FIFO_DEPTH   = 64,
    parameter logic [7:0]  EOL_CHAR     = 8'h0a
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              uart_rxd,
    input  logic                              uart_rx_en,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [7:0]                        m_data,
    output logic                              m_last,
    output logic                              m_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   lines_pending,
    output logic                              overflow,
    input  logic                              clear_overflow,
    output logic                              rx_break
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CPB - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(PAYLOAD_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

    logic        rx_meta;
    logic        rxs;
    rx_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  data_q;
    logic        par_zero;
    logic        perr;
    logic        ferr;
    logic        stop0;
    logic        push_q;
    uart_entry_t push_entry;

    logic        tick;
    logic        ferr_now;
    logic        first_stop;
    logic        is_break;

    assign tick       = (cnt == '0);
    assign ferr_now   = ferr | ~rxs;
    assign first_stop = (stop_idx == 1'b0) ? rxs : stop0;
    assign is_break   = (data_q == 8'h00) && par_zero && !first_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            data_q     <= '0;
            par_zero   <= 1'b1;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            stop0      <= 1'b1;
            push_q     <= 1'b0;
            push_entry <= '0;
            rx_break   <= 1'b0;
        end else begin
            rx_meta  <= uart_rxd;
            rxs      <= rx_meta;
            push_q   <= 1'b0;
            rx_break <= 1'b0;
            if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
                cnt <= tick ? CNT_FULL : cnt - 1'b1;
            case (state)
                ST_IDLE: begin
                    if (uart_rx_en && !rxs) begin
                        cnt      <= CNT_HALF;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        data_q   <= '0;
                        par_zero <= 1'b1;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) state <= rxs ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (tick) begin
                        data_q[bit_idx] <= rxs;
                        if (bit_idx == LAST_BIT)
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        par_zero <= !rxs;
                        perr     <= (rxs != ((^data_q) ^ ODD_PAR));
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_idx == 1'b0) stop0 <= rxs;
                        if (!rxs) ferr <= 1'b1;
                        // The push decision uses the current sample, hence ferr_now/first_stop.
                        if (stop_idx == LAST_STOP) begin
                            if (is_break) begin
                                rx_break <= 1'b1;
                                state    <= ST_WAIT_HIGH;
                            end else begin
                                push_q          <= 1'b1;
                                push_entry.data <= data_q;
                                push_entry.last <= (data_q == EOL_CHAR);
                                push_entry.err  <= perr | ferr_now;
                                state           <= ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_entry_t  head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  fifo_count;
    logic         pop;
    logic         accepted;
    logic         drop;
    logic         lp_inc;
    logic         lp_dec;

    uart_sync_fifo #(
        .WIDTH ($bits(uart_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_q),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid  = !fifo_empty;
    assign pop      = m_valid && m_ready;
    assign accepted = push_q && (!fifo_full || pop);
    assign drop     = push_q && fifo_full && !pop;
    assign lp_inc   = accepted && push_entry.last;
    assign lp_dec   = pop && head.last;

    assign m_data = m_valid ? head.data : 8'h00;
    assign m_last = m_valid && head.last;
    assign m_err  = m_valid && head.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow      <= 1'b0;
            lines_pending <= '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
            case ({lp_inc, lp_dec})
                2'b10:   lines_pending <= lines_pending + 1'b1;
                2'b01:   lines_pending <= lines_pending - 1'b1;
                default: lines_pending <= lines_pending;
            endcase
        end
    end

    // Every counted line terminator must still be sitting in the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) assert (lines_pending <= fifo_count);
    end

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// tb/tb_uart_rx_line_buffer.sv - directed bench for uart_rx_line_buffer (8N1 and 8E2 instances)
module tb_uart_rx_line_buffer;

    localparam int CPB = 10;
    localparam int GAP = 20;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        int         lp;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       par_bit;
        logic       stop2;
        int         extra_low;
        logic       exp_last;
        logic       exp_err;
        int         exp_lp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd_a, rxd_b;
    logic       en;
    logic       rdy_a, rdy_b;
    logic       clr_a, clr_b;
    logic       valid_a, valid_b;
    logic [7:0] data_a, data_b;
    logic       last_a, last_b;
    logic       err_a, err_b;
    logic [2:0] lp_a, lp_b;
    logic       ovf_a, ovf_b;
    logic       brk_a, brk_b;

    beat_t qa[$];
    beat_t qb[$];
    int    brk_cnt_a = 0;
    int    brk_cnt_b = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_line_buffer #(
        .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .EOL_CHAR(8'h0a)
    ) dut_a (
        .clk(clk), .reset(reset), .uart_rxd(rxd_a), .uart_rx_en(en),
        .m_valid(valid_a), .m_ready(rdy_a), .m_data(data_a), .m_last(last_a),
        .m_err(err_a), .lines_pending(lp_a), .overflow(ovf_a),
        .clear_overflow(clr_a), .rx_break(brk_a)
    );

    uart_rx_line_buffer #(
        .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
        .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .EOL_CHAR(8'h0a)
    ) dut_b (
        .clk(clk), .reset(reset), .uart_rxd(rxd_b), .uart_rx_en(en),
        .m_valid(valid_b), .m_ready(rdy_b), .m_data(data_b), .m_last(last_b),
        .m_err(err_b), .lines_pending(lp_b), .overflow(ovf_b),
        .clear_overflow(clr_b), .rx_break(brk_b)
    );

    // Sample just after the falling edge so inputs driven on that edge have settled.
    always begin
        beat_t b;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (valid_a && rdy_a) begin
                b.data = data_a; b.last = last_a; b.err = err_a; b.lp = int'(lp_a);
                qa.push_back(b);
            end
            if (valid_b && rdy_b) begin
                b.data = data_b; b.last = last_b; b.err = err_b; b.lp = int'(lp_b);
                qb.push_back(b);
            end
            if (brk_a) brk_cnt_a++;
            if (brk_b) brk_cnt_b++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v, input int cycles);
        if (inst == 0) rxd_a = v;
        else           rxd_b = v;
        repeat (cycles) @(negedge clk);
    endtask

    // inst 0 frames are 8N1; inst 1 frames are 8E2.
    task automatic send(input int inst, input logic [7:0] d, input logic par_bit,
                        input logic stop2, input int extra_low);
        drive(inst, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(inst, d[i], CPB);
        if (inst == 1) drive(inst, par_bit, CPB);
        drive(inst, 1'b1, CPB);
        if (inst == 1) drive(inst, stop2, CPB);
        if (extra_low > 0) drive(inst, 1'b0, extra_low);
        drive(inst, 1'b1, GAP);
    endtask

    task automatic get_beat(input int inst, output beat_t b, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        b  = '{default: '0};
        while (((inst == 0) ? qa.size() : qb.size()) == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (inst == 0 && qa.size() > 0) begin
            b = qa.pop_front(); ok = 1'b1;
        end else if (inst == 1 && qb.size() > 0) begin
            b = qb.pop_front(); ok = 1'b1;
        end
    endtask

    task automatic cmp_beat(input string nm, input int inst, input logic [7:0] d,
                            input logic l, input logic e, input int lp);
        beat_t b;
        bit    ok;
        get_beat(inst, b, ok);
        check({nm, "_present"}, 32'(ok), 32'd1);
        if (ok) begin
            check({nm, "_data"}, 32'(b.data), 32'(d));
            check({nm, "_last"}, 32'(b.last), 32'(l));
            check({nm, "_err"},  32'(b.err),  32'(e));
            check({nm, "_lp"},   b.lp,        lp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        va[3];
        vec_t        vb[4];
        logic [7:0]  ov[5];
        int          brk0;

        va[0] = '{8'h48, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0};
        va[1] = '{8'h69, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0};
        va[2] = '{8'h0a, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
        vb[0] = '{8'h07, 1'b0, 1'b1, 0,  1'b0, 1'b1, 0};
        vb[1] = '{8'h07, 1'b1, 1'b1, 0,  1'b0, 1'b0, 0};
        vb[2] = '{8'h55, 1'b0, 1'b0, 15, 1'b0, 1'b1, 0};
        vb[3] = '{8'h41, 1'b0, 1'b1, 0,  1'b0, 1'b0, 0};
        ov[0] = 8'h31; ov[1] = 8'h0a; ov[2] = 8'h33; ov[3] = 8'h34; ov[4] = 8'h35;

        reset = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; en = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_data",  32'(data_a),  0);
        check("rst_last",  32'(last_a),  0);
        check("rst_err",   32'(err_a),   0);
        check("rst_lp",    32'(lp_a),    0);
        check("rst_ovf",   32'(ovf_a),   0);
        check("rst_brk",   32'(brk_a),   0);
        check("rst_valid_b", 32'(valid_b), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            send(0, va[i].data, va[i].par_bit, va[i].stop2, va[i].extra_low);
            cmp_beat($sformatf("a_line%0d", i), 0, va[i].data, va[i].exp_last,
                     va[i].exp_err, va[i].exp_lp);
        end
        check("a_line_lp_end", 32'(lp_a), 0);

        for (int i = 0; i < 4; i++) begin
            send(1, vb[i].data, vb[i].par_bit, vb[i].stop2, vb[i].extra_low);
            cmp_beat($sformatf("b_frame%0d", i), 1, vb[i].data, vb[i].exp_last,
                     vb[i].exp_err, vb[i].exp_lp);
        end
        repeat (50) @(negedge clk);
        check("b_no_extra", qb.size(), 0);

        brk0 = brk_cnt_a;
        drive(0, 1'b0, 20 * CPB);
        drive(0, 1'b1, 30);
        check("brk_pulse_cycles", brk_cnt_a - brk0, 1);
        check("brk_no_push", qa.size(), 0);
        send(0, 8'h41, 1'b0, 1'b1, 0);
        cmp_beat("after_brk", 0, 8'h41, 1'b0, 1'b0, 0);

        drive(0, 1'b0, 3);
        drive(0, 1'b1, 150);
        check("glitch_no_push", qa.size(), 0);
        check("glitch_valid", 32'(valid_a), 0);

        rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) send(0, ov[i], 1'b0, 1'b1, 0);
        check("ovf_before", 32'(ovf_a), 0);
        check("ovf_full_head", 32'(data_a), 32'h31);
        check("ovf_full_lp", 32'(lp_a), 1);
        send(0, ov[4], 1'b0, 1'b1, 0);
        check("ovf_set", 32'(ovf_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(ovf_a), 0);
        rdy_a = 1'b1;
        cmp_beat("drain0", 0, 8'h31, 1'b0, 1'b0, 1);
        cmp_beat("drain1", 0, 8'h0a, 1'b1, 1'b0, 1);
        cmp_beat("drain2", 0, 8'h33, 1'b0, 1'b0, 0);
        cmp_beat("drain3", 0, 8'h34, 1'b0, 1'b0, 0);
        repeat (10) @(negedge clk);
        check("drain_no_fifth", qa.size(), 0);

        rdy_a = 1'b0;
        send(0, 8'h0a, 1'b0, 1'b1, 0);
        check("pre_rst_lp", 32'(lp_a), 1);
        drive(0, 1'b0, 25);
        rxd_a = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_data",  32'(data_a),  0);
        check("mid_rst_last",  32'(last_a),  0);
        check("mid_rst_lp",    32'(lp_a),    0);
        check("mid_rst_ovf",   32'(ovf_a),   0);
        reset = 1'b0;
        rdy_a = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_empty", qa.size(), 0);
        send(0, 8'h42, 1'b0, 1'b1, 0);
        cmp_beat("post_rst", 0, 8'h42, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
